perf_counter_bank: RTL and testbench

Parametrised hardware performance-counter bank; the successor to the fixed seven-field `PerfCounterPath` export.
- Accumulates `NUM_EVENTS` event channels, each incrementing by up to `2^INC_WIDTH-1` per cycle, into `COUNTER_WIDTH`-bit live counters.
- Selectable wrap or saturate mode, sticky per-channel overflow flags, and per-channel enable.
- Software-triggered or periodic (windowed) snapshots; snapshot values are read through an indexed request/response port.
- Sits beside the debug register path. Pipeline stages drive `eventInc`; the debug/host side reads results.

---
 rtl/perf_counter_bank_pkg.sv | 27 ++
 rtl/perf_counter_cell.sv | 56 +++++
 rtl/perf_counter_bank.sv | 136 +++++++++++++
 tb/tb_perf_counter_bank.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_counter_bank_pkg.sv
// Shared types and constants for the performance-counter bank.
// Carries the read-port state encoding, the snapshot sequence width and the
// fixed seven-channel export type still used by the legacy debug path.
package perf_counter_bank_pkg;

   localparam int PERF_SNAPSHOT_SEQ_WIDTH   = 8;
   localparam int PERF_LEGACY_NUM_EVENTS    = 7;
   localparam int PERF_LEGACY_COUNTER_WIDTH = 32;

   // Index width for a bank of num_events channels; never narrower than 1 bit.
   function automatic int perf_index_width(input int num_events);
      return (num_events > 1) ? $clog2(num_events) : 1;
   endfunction

   // Channel index as seen by the seven-channel debug instance.
   typedef logic [perf_index_width(PERF_LEGACY_NUM_EVENTS)-1:0] perf_event_index_t;

   // Read-port handshake states.
   typedef enum logic [0:0] {
      PERF_RD_IDLE = 1'b0,
      PERF_RD_RESP = 1'b1
   } perf_read_state_e;

   // Legacy fixed export: seven 32-bit counter fields.
   typedef logic [PERF_LEGACY_NUM_EVENTS-1:0][PERF_LEGACY_COUNTER_WIDTH-1:0] perf_counter_path_t;

endpackage : perf_counter_bank_pkg

// File: rtl/perf_counter_cell.sv
// One counter channel: live counter with wrap/saturate arithmetic, a sticky
// overflow flag, and the snapshot register that the read port selects from.
module perf_counter_cell #(
   parameter int COUNTER_WIDTH = 32,
   parameter int INC_WIDTH     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INC_WIDTH-1:0]     inc,
   input  logic                     enable,
   input  logic                     saturate,
   input  logic                     clear,
   input  logic                     capture,
   output logic [COUNTER_WIDTH-1:0] snap_value,
   output logic                     snap_overflow
);

   logic [COUNTER_WIDTH-1:0] cnt;
   logic                     overflow;
   logic [COUNTER_WIDTH:0]   sum;
   logic                     carry;

   // One extra bit on the adder exposes the carry that marks an overflow.
   assign sum   = {1'b0, cnt} + {{(COUNTER_WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
   assign carry = sum[COUNTER_WIDTH];

   // Live counter and sticky overflow: clear beats increment, disabled holds.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         cnt      <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         cnt      <= '0;
         overflow <= 1'b0;
      end else if (enable) begin
         cnt <= (carry && saturate) ? {COUNTER_WIDTH{1'b1}} : sum[COUNTER_WIDTH-1:0];
         if (carry) begin
            overflow <= 1'b1;
         end
      end
   end

   // Snapshot register: captures the value before this cycle's update or clear.
   always_ff @(posedge clk) begin
      // NOTE: snapshots are reset too, because reads after reset must return 0.
      if (rst) begin
         snap_value    <= '0;
         snap_overflow <= 1'b0;
      end else if (capture) begin
         snap_value    <= cnt;
         snap_overflow <= overflow;
      end
   end

endmodule : perf_counter_cell

// File: rtl/perf_counter_bank.sv
// Parametrised performance-counter bank. Holds the window counter, the
// snapshot sequence counter and the indexed read FSM; the per-channel
// counters live in perf_counter_cell instances.
module perf_counter_bank
   import perf_counter_bank_pkg::*;
#(
   parameter int NUM_EVENTS    = 7,
   parameter int COUNTER_WIDTH = 32,
   parameter int INC_WIDTH     = 2
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_EVENTS*INC_WIDTH-1:0]         eventInc,
   input  logic [NUM_EVENTS-1:0]                   enableMask,
   input  logic                                    saturate,
   input  logic                                    clearReq,
   input  logic                                    snapshotReq,
   input  logic [COUNTER_WIDTH-1:0]                windowLength,
   input  logic                                    rdReqValid,
   input  logic [perf_index_width(NUM_EVENTS)-1:0] rdIndex,
   output logic                                    rdReqReady,
   output logic                                    rdRespValid,
   input  logic                                    rdRespReady,
   output logic [COUNTER_WIDTH-1:0]                rdData,
   output logic                                    rdOverflow,
   output logic                                    snapshotDone,
   output logic [PERF_SNAPSHOT_SEQ_WIDTH-1:0]      snapshotSeq
);

   localparam int IDX_W = perf_index_width(NUM_EVENTS);

   logic [COUNTER_WIDTH-1:0] win_cnt;
   logic                     win_expire;
   logic                     clear_all;
   logic                     capture;

   logic [COUNTER_WIDTH-1:0] snap_data [NUM_EVENTS];
   logic [NUM_EVENTS-1:0]    snap_ovf;

   logic [COUNTER_WIDTH-1:0] sel_data;
   logic                     sel_ovf;

   perf_read_state_e         rd_state;

   // Expiry uses >= so shrinking windowLength below the running count still fires.
   assign win_expire = (windowLength != '0) && (win_cnt >= (windowLength - COUNTER_WIDTH'(1)));
   assign clear_all  = clearReq || win_expire;
   assign capture    = snapshotReq || win_expire;

   // Per-channel counters, overflow flags and snapshot registers.
   for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cell
      perf_counter_cell #(
         .COUNTER_WIDTH (COUNTER_WIDTH),
         .INC_WIDTH     (INC_WIDTH)
      ) u_cell (
         .clk           (clk),
         .rst           (rst),
         .inc           (eventInc[i*INC_WIDTH +: INC_WIDTH]),
         .enable        (enableMask[i]),
         .saturate      (saturate),
         .clear         (clear_all),
         .capture       (capture),
         .snap_value    (snap_data[i]),
         .snap_overflow (snap_ovf[i])
      );
   end

   // Window counter: runs while windowing is enabled, restarts on any clear.
   always_ff @(posedge clk) begin
      if (rst || clear_all) begin
         win_cnt <= '0;
      end else if (windowLength != '0) begin
         win_cnt <= win_cnt + COUNTER_WIDTH'(1);
      end
   end

   // Snapshot pulse and sequence number, both visible the cycle after capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         snapshotDone <= 1'b0;
         snapshotSeq  <= '0;
      end else begin
         snapshotDone <= capture;
         if (capture) begin
            snapshotSeq <= snapshotSeq + PERF_SNAPSHOT_SEQ_WIDTH'(1);
         end
      end
   end

   // Snapshot read mux; indices past the last channel return zero.
   always_comb begin
      // NOTE: defaults first so no path through the loop leaves a latch.
      sel_data = '0;
      sel_ovf  = 1'b0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (rdIndex == IDX_W'(i)) begin
            sel_data = snap_data[i];
            sel_ovf  = snap_ovf[i];
         end
      end
   end

   assign rdReqReady = !rst && (rd_state == PERF_RD_IDLE);

   // Read FSM: latch the selected snapshot on accept, hold it until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state    <= PERF_RD_IDLE;
         rdRespValid <= 1'b0;
         rdData      <= '0;
         rdOverflow  <= 1'b0;
      end else begin
         case (rd_state)
            PERF_RD_IDLE: begin
               if (rdReqValid) begin
                  rdData      <= sel_data;
                  rdOverflow  <= sel_ovf;
                  rdRespValid <= 1'b1;
                  rd_state    <= PERF_RD_RESP;
               end
            end
            PERF_RD_RESP: begin
               if (rdRespReady) begin
                  rdRespValid <= 1'b0;
                  rd_state    <= PERF_RD_IDLE;
               end
            end
            default: begin
               rdRespValid <= 1'b0;
               rd_state    <= PERF_RD_IDLE;
            end
         endcase
      end
   end

endmodule : perf_counter_bank

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a default 7x32 instance for counting,
// reads, clears, windowing and reset, and a 2x4 instance for wrap/saturate.
module tb_perf_counter_bank;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // Main instance (7 channels, 32-bit counters).
   logic [13:0] eventInc     = '0;
   logic [6:0]  enableMask   = '1;
   logic        saturate     = 1'b0;
   logic        clearReq     = 1'b0;
   logic        snapshotReq  = 1'b0;
   logic [31:0] windowLength = '0;
   logic        rdReqValid   = 1'b0;
   logic [2:0]  rdIndex      = '0;
   logic        rdReqReady;
   logic        rdRespValid;
   logic        rdRespReady  = 1'b1;
   logic [31:0] rdData;
   logic        rdOverflow;
   logic        snapshotDone;
   logic [7:0]  snapshotSeq;

   // Small instance (2 channels, 4-bit counters).
   logic [3:0]  s_eventInc     = '0;
   logic [1:0]  s_enableMask   = '1;
   logic        s_saturate     = 1'b0;
   logic        s_clearReq     = 1'b0;
   logic        s_snapshotReq  = 1'b0;
   logic [3:0]  s_windowLength = '0;
   logic        s_rdReqValid   = 1'b0;
   logic [0:0]  s_rdIndex      = '0;
   logic        s_rdReqReady;
   logic        s_rdRespValid;
   logic        s_rdRespReady  = 1'b1;
   logic [3:0]  s_rdData;
   logic        s_rdOverflow;
   logic        s_snapshotDone;
   logic [7:0]  s_snapshotSeq;

   int n_checks = 0;
   int n_errors = 0;

   perf_counter_bank #(.NUM_EVENTS(7), .COUNTER_WIDTH(32), .INC_WIDTH(2)) u_dut (
      .clk(clk), .rst(rst), .eventInc(eventInc), .enableMask(enableMask),
      .saturate(saturate), .clearReq(clearReq), .snapshotReq(snapshotReq),
      .windowLength(windowLength), .rdReqValid(rdReqValid), .rdIndex(rdIndex),
      .rdReqReady(rdReqReady), .rdRespValid(rdRespValid), .rdRespReady(rdRespReady),
      .rdData(rdData), .rdOverflow(rdOverflow), .snapshotDone(snapshotDone),
      .snapshotSeq(snapshotSeq)
   );

   perf_counter_bank #(.NUM_EVENTS(2), .COUNTER_WIDTH(4), .INC_WIDTH(2)) u_dut_small (
      .clk(clk), .rst(rst), .eventInc(s_eventInc), .enableMask(s_enableMask),
      .saturate(s_saturate), .clearReq(s_clearReq), .snapshotReq(s_snapshotReq),
      .windowLength(s_windowLength), .rdReqValid(s_rdReqValid), .rdIndex(s_rdIndex),
      .rdReqReady(s_rdReqReady), .rdRespValid(s_rdRespValid), .rdRespReady(s_rdRespReady),
      .rdData(s_rdData), .rdOverflow(s_rdOverflow), .snapshotDone(s_snapshotDone),
      .snapshotSeq(s_snapshotSeq)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inc(input int ch, input int val);
      eventInc = '0;
      eventInc[ch*2 +: 2] = 2'(val);
   endtask

   task automatic pulse_snapshot(input bit sm);
      if (sm) s_snapshotReq = 1'b1; else snapshotReq = 1'b1;
      tick();
      s_snapshotReq = 1'b0;
      snapshotReq   = 1'b0;
   endtask

   task automatic pulse_clear(input bit sm);
      if (sm) s_clearReq = 1'b1; else clearReq = 1'b1;
      tick();
      s_clearReq = 1'b0;
      clearReq   = 1'b0;
   endtask

   // Full read transaction with rdRespReady high; waits for the response within a bound.
   task automatic do_read(input bit sm, input int idx, output logic [31:0] data, output logic ovf);
      int n;
      if (sm) begin
         s_rdReqValid = 1'b1; s_rdIndex = 1'(idx); s_rdRespReady = 1'b1;
      end else begin
         rdReqValid = 1'b1; rdIndex = 3'(idx); rdRespReady = 1'b1;
      end
      tick();
      s_rdReqValid = 1'b0;
      rdReqValid   = 1'b0;
      n = 0;
      while (!(sm ? s_rdRespValid : rdRespValid) && n < 8) begin
         tick();
         n++;
      end
      check("rd_resp_valid", 32'(sm ? s_rdRespValid : rdRespValid), 32'd1);
      data = sm ? 32'(s_rdData) : rdData;
      ovf  = sm ? s_rdOverflow : rdOverflow;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic        o;

      // Reset state.
      tick();
      tick();
      check("rst_req_ready", 32'(rdReqReady), 32'd0);
      check("rst_resp_valid", 32'(rdRespValid), 32'd0);
      check("rst_rd_data", rdData, 32'd0);
      check("rst_seq", 32'(snapshotSeq), 32'd0);
      check("rst_done", 32'(snapshotDone), 32'd0);
      rst = 1'b0;
      #1;
      check("req_ready_after_rst", 32'(rdReqReady), 32'd1);

      // Count and read: 10 x 3 on channel 0.
      set_inc(0, 3);
      for (int i = 0; i < 10; i++) tick();
      eventInc = '0;
      pulse_snapshot(1'b0);
      check("t1_done", 32'(snapshotDone), 32'd1);
      check("t1_seq", 32'(snapshotSeq), 32'd1);
      tick();
      check("t1_done_drop", 32'(snapshotDone), 32'd0);
      do_read(1'b0, 0, d, o);
      check("t1_data", d, 32'd30);
      check("t1_ovf", 32'(o), 32'd0);

      // Saturate on the 4-bit instance: 3+3+3+3+3 = 15 reaches all-ones without carry.
      s_saturate = 1'b1;
      s_eventInc = 4'b0011;
      for (int i = 0; i < 5; i++) tick();
      s_eventInc = '0;
      pulse_snapshot(1'b1);
      do_read(1'b1, 0, d, o);
      check("sat_exact_data", d, 32'd15);
      check("sat_exact_ovf", 32'(o), 32'd0);
      // Sixth increment carries: held at 15, overflow set.
      s_eventInc = 4'b0011;
      tick();
      s_eventInc = '0;
      pulse_snapshot(1'b1);
      do_read(1'b1, 0, d, o);
      check("sat_data", d, 32'd15);
      check("sat_ovf", 32'(o), 32'd1);
      // Wrap mode, same stimulus: 18 mod 16 = 2.
      pulse_clear(1'b1);
      s_saturate = 1'b0;
      s_eventInc = 4'b0011;
      for (int i = 0; i < 6; i++) tick();
      s_eventInc = '0;
      pulse_snapshot(1'b1);
      do_read(1'b1, 0, d, o);
      check("wrap_data", d, 32'd2);
      check("wrap_ovf", 32'(o), 32'd1);
      check("small_seq", 32'(s_snapshotSeq), 32'd3);

      // Simultaneous clear and snapshot after counting to 5 on channel 1.
      pulse_clear(1'b0);
      set_inc(1, 1);
      for (int i = 0; i < 5; i++) tick();
      eventInc    = '0;
      clearReq    = 1'b1;
      snapshotReq = 1'b1;
      tick();
      clearReq    = 1'b0;
      snapshotReq = 1'b0;
      do_read(1'b0, 1, d, o);
      check("clrsnap_data", d, 32'd5);
      pulse_snapshot(1'b0);
      do_read(1'b0, 1, d, o);
      check("after_clr_data", d, 32'd0);
      check("after_clr_ovf", 32'(o), 32'd0);
      check("t3_seq", 32'(snapshotSeq), 32'd3);

      // Read backpressure: channel 2 counts to 8, snapshot, then hold the response.
      pulse_clear(1'b0);
      set_inc(2, 2);
      for (int i = 0; i < 4; i++) tick();
      eventInc = '0;
      pulse_snapshot(1'b0);
      rdReqValid  = 1'b1;
      rdIndex     = 3'd2;
      rdRespReady = 1'b0;
      tick();
      rdReqValid = 1'b0;
      check("bp_valid", 32'(rdRespValid), 32'd1);
      check("bp_data0", rdData, 32'd8);
      // Counter keeps moving: 10, 12 (captured), 14, 16, 18.
      set_inc(2, 2);
      for (int k = 0; k < 5; k++) begin
         snapshotReq = (k == 2);
         tick();
         check("bp_data_hold", rdData, 32'd8);
         check("bp_req_ready", 32'(rdReqReady), 32'd0);
      end
      snapshotReq = 1'b0;
      eventInc    = '0;
      rdRespReady = 1'b1;
      tick();
      check("bp_release", 32'(rdRespValid), 32'd0);
      do_read(1'b0, 2, d, o);
      check("bp_new_data", d, 32'd12);

      // Disabled channel 3 next to enabled channel 0, then out-of-range index.
      pulse_clear(1'b0);
      enableMask = 7'b1110111;
      eventInc   = '0;
      eventInc[1:0] = 2'd3;
      eventInc[7:6] = 2'd3;
      for (int i = 0; i < 4; i++) tick();
      eventInc = '0;
      pulse_snapshot(1'b0);
      enableMask = '1;
      do_read(1'b0, 3, d, o);
      check("dis_data", d, 32'd0);
      do_read(1'b0, 0, d, o);
      check("en_data", d, 32'd12);
      do_read(1'b0, 7, d, o);
      check("oor_data", d, 32'd0);
      check("oor_ovf", 32'(o), 32'd0);
      check("t6_seq", 32'(snapshotSeq), 32'd6);

      // Reset while a response is pending.
      rdReqValid  = 1'b1;
      rdIndex     = 3'd0;
      rdRespReady = 1'b0;
      tick();
      rdReqValid = 1'b0;
      check("mid_valid", 32'(rdRespValid), 32'd1);
      check("mid_data", rdData, 32'd12);
      rst = 1'b1;
      tick();
      check("mid_rst_valid", 32'(rdRespValid), 32'd0);
      check("mid_rst_ready", 32'(rdReqReady), 32'd0);
      check("mid_rst_seq", 32'(snapshotSeq), 32'd0);
      rst         = 1'b0;
      rdRespReady = 1'b1;
      tick();
      do_read(1'b0, 0, d, o);
      check("post_rst_snap0", d, 32'd0);
      do_read(1'b1, 0, d, o);
      check("post_rst_small", d, 32'd0);

      // Window of 4 with inc=1: expiry clears the counter and drops that cycle's
      // increment, so each window accumulates 3 events.
      windowLength = 32'd4;
      set_inc(0, 1);
      for (int e = 1; e <= 1024; e++) begin
         tick();
         if (e <= 12) check("win_done", 32'(snapshotDone), 32'((e % 4) == 0));
         if (e == 4)    check("win_seq_first", 32'(snapshotSeq), 32'd1);
         if (e == 1020) check("win_seq_255", 32'(snapshotSeq), 32'd255);
         if (e == 1024) check("win_seq_wrap", 32'(snapshotSeq), 32'd0);
      end
      do_read(1'b0, 0, d, o);
      check("win_data", d, 32'd3);
      check("win_ovf", 32'(o), 32'd0);
      windowLength = '0;
      eventInc     = '0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_perf_counter_bank
